// File: rtl/ptr_sync_pkg.sv
// Shared helpers and limits for the gray-pointer synchronizer.
// Gray decode and popcount work on a fixed maximum width; callers zero-extend.
package ptr_sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int PTR_W_MAX  = 32;
  localparam int CNT_W      = 3;

  // Leading zeros decode to zeros, so one wide decoder serves any pointer width.
  function automatic logic [PTR_W_MAX-1:0] g2b(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [PTR_W_MAX-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ptr_sync_chan.sv
// One pointer channel: sync chain, gray/binary hold, advance, change pulse and
// optional sticky illegal-jump flag (built when PTR_SYNC_ERRCHK_EN is defined).
module ptr_sync_chan
  import ptr_sync_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic         vld,
  input  logic [W-1:0] wptr,
  input  logic         err_clr,
  output logic [W-1:0] rq_gray,
  output logic [W-1:0] rq_bin,
  output logic [W-1:0] rq_delta,
  output logic         rq_chg,
  output logic         rq_err
);

  logic [W-1:0] sync_r [STAGES];
  logic [W-1:0] gray_r;
  logic [W-1:0] bin_r;
  logic [W-1:0] delta_r;
  logic         chg_r;
  logic         err_r;

  logic [W-1:0] s_last_s;
  logic [W-1:0] bin_next_s;
  logic [W-1:0] delta_next_s;
  logic         chg_next_s;
  logic         err_next_s;

  assign s_last_s = sync_r[STAGES-1];

  // Plain flop chain, nothing between stages.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= wptr;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Decode, advance and change detection; silent until the warm-up completes.
  always_comb begin
    bin_next_s   = W'(g2b(PTR_W_MAX'(s_last_s)));
    delta_next_s = '0;
    chg_next_s   = 1'b0;
    if (vld) begin
      delta_next_s = bin_next_s - bin_r;
      chg_next_s   = (s_last_s != gray_r);
    end else begin
      delta_next_s = '0;
      chg_next_s   = 1'b0;
    end
  end

`ifdef PTR_SYNC_ERRCHK_EN
  // A set on the same edge as a clear must win.
  always_comb begin
    err_next_s = err_r;
    if (vld && (popcount(PTR_W_MAX'(s_last_s ^ gray_r)) > 6'd1)) begin
      err_next_s = 1'b1;
    end else if (err_clr) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;

  // Checker not built: flag stays low.
  always_comb begin
    err_next_s = 1'b0;
  end
`endif

  // Output hold registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      gray_r  <= '0;
      bin_r   <= '0;
      delta_r <= '0;
      chg_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      gray_r  <= s_last_s;
      bin_r   <= bin_next_s;
      delta_r <= delta_next_s;
      chg_r   <= chg_next_s;
      err_r   <= err_next_s;
    end
  end

  assign rq_gray  = gray_r;
  assign rq_bin   = bin_r;
  assign rq_delta = delta_r;
  assign rq_chg   = chg_r;
  assign rq_err   = err_r;

endmodule

// File: rtl/ptr_sync_multi.sv
// Multi-channel gray-pointer synchronizer into the rclk domain with shared warm-up.
// Optional jump checker: define PTR_SYNC_ERRCHK_EN.
module ptr_sync_multi
  import ptr_sync_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2,
  parameter int NCH      = 1
) (
  input  logic                         rclk,
  input  logic                         rrst,
  input  logic [NCH*(ADDRSIZE+1)-1:0]  wptr,
  input  logic [NCH-1:0]               err_clr,
  output logic [NCH*(ADDRSIZE+1)-1:0]  rq_gray,
  output logic [NCH*(ADDRSIZE+1)-1:0]  rq_bin,
  output logic [NCH*(ADDRSIZE+1)-1:0]  rq_delta,
  output logic [NCH-1:0]               rq_chg,
  output logic                         rq_vld,
  output logic [NCH-1:0]               rq_err
);

  localparam int W = ADDRSIZE + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STAGES + 1);

  if ((STAGES < STAGES_MIN) || (STAGES > STAGES_MAX)) begin : g_bad_stages
    $fatal(1, "ptr_sync_multi: STAGES must be within 2..4");
  end

  logic [CNT_W-1:0] cnt_r;
  logic             vld_r;

  // Warm-up: outputs become meaningful once the chain and hold are filled.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_r <= '0;
      vld_r <= 1'b0;
    end else begin
      if (cnt_r != CNT_SAT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      vld_r <= vld_r | (cnt_r == CNT_LAST);
    end
  end

  assign rq_vld = vld_r;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ptr_sync_chan #(
      .W      (W),
      .STAGES (STAGES)
    ) u_chan (
      .rclk     (rclk),
      .rrst     (rrst),
      .vld      (vld_r),
      .wptr     (wptr[i*W +: W]),
      .err_clr  (err_clr[i]),
      .rq_gray  (rq_gray[i*W +: W]),
      .rq_bin   (rq_bin[i*W +: W]),
      .rq_delta (rq_delta[i*W +: W]),
      .rq_chg   (rq_chg[i]),
      .rq_err   (rq_err[i])
    );
  end

endmodule
